// File: rtl/s_memory_decrypt.sv
// s_memory_decrypt
//   RC4 PRGA / decrypt stage. After the key-scheduling shuffle has finished,
//   this block owns the shared 256x8 S memory. For each message byte k it
//   steps i and j, swaps S[i] and S[j], and reads the keystream byte
//   f = S[S[i]+S[j]]. The encrypted byte ROM[k] is XORed with f and written to
//   the decrypted-message RAM. text_ok stays high only while every byte
//   written so far is lowercase a-z or space.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    synchronous active-low reset
//   start      level; sampled in IDLE to begin a run
//   s_addr     S memory address
//   s_data     S memory write data
//   s_wren     S memory write enable
//   s_q        S memory read data (one-cycle synchronous read)
//   rom_addr   encrypted-message ROM address
//   rom_q      encrypted-message ROM data (one-cycle synchronous read)
//   dec_addr   decrypted RAM address
//   dec_data   decrypted RAM write data
//   dec_wren   decrypted RAM write enable
//   done       high while in DONE
//   text_ok    sticky plausibility flag for the current run
//
// state     | meaning
// IDLE      | wait for start; clears i, j, k and re-arms text_ok
// INC_I     | i <= i + 1
// READ_SI   | present S address i
// WAIT_SI   | hold address i, capture si
// CALC_J    | j <= j + si
// READ_SJ   | present S address j
// WAIT_SJ   | hold address j, capture sj
// WRITE_SI  | S[i] <= sj
// WRITE_SJ  | S[j] <= si
// READ_F    | present S address si+sj and ROM address k
// WAIT_F    | hold addresses, capture f and enc
// WRITE_DEC | dec[k] <= f ^ enc, update text_ok
// NEXT_K    | last byte -> DONE, otherwise k <= k + 1
// DONE      | done high; leave when start drops

module s_memory_decrypt #(
  parameter int MSG_LEN = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic [7:0] s_addr,
  output logic [7:0] s_data,
  output logic       s_wren,
  input  logic [7:0] s_q,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_q,
  output logic [7:0] dec_addr,
  output logic [7:0] dec_data,
  output logic       dec_wren,
  output logic       done,
  output logic       text_ok
);

  typedef enum logic [3:0] {
    IDLE, INC_I, READ_SI, WAIT_SI, CALC_J, READ_SJ, WAIT_SJ,
    WRITE_SI, WRITE_SJ, READ_F, WAIT_F, WRITE_DEC, NEXT_K, DONE
  } state_t;

  localparam logic [7:0] K_LAST = 8'(MSG_LEN - 1);

  state_t     state, state_nxt;
  logic [7:0] i, j, k, si, sj, f, enc;
  logic [7:0] plain;
  logic       plain_ok;

  assign plain    = f ^ enc;
  assign plain_ok = ((plain >= 8'h61) && (plain <= 8'h7a)) || (plain == 8'h20);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      i       <= 8'd0;
      j       <= 8'd0;
      k       <= 8'd0;
      si      <= 8'd0;
      sj      <= 8'd0;
      f       <= 8'd0;
      enc     <= 8'd0;
      text_ok <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            i       <= 8'd0;
            j       <= 8'd0;
            k       <= 8'd0;
            text_ok <= 1'b1;
          end
        end
        INC_I:   i  <= i + 8'd1;
        WAIT_SI: si <= s_q;
        CALC_J:  j  <= j + si;
        WAIT_SJ: sj <= s_q;
        WAIT_F: begin
          f   <= s_q;
          enc <= rom_q;
        end
        WRITE_DEC: if (!plain_ok) text_ok <= 1'b0;
        NEXT_K:    if (k != K_LAST) k <= k + 8'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    s_addr    = 8'd0;
    s_data    = 8'd0;
    s_wren    = 1'b0;
    rom_addr  = 8'd0;
    dec_addr  = 8'd0;
    dec_data  = 8'd0;
    dec_wren  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = INC_I;
      INC_I:   state_nxt = READ_SI;
      READ_SI: begin
        s_addr    = i;
        state_nxt = WAIT_SI;
      end
      WAIT_SI: begin
        s_addr    = i;
        state_nxt = CALC_J;
      end
      CALC_J:  state_nxt = READ_SJ;
      READ_SJ: begin
        s_addr    = j;
        state_nxt = WAIT_SJ;
      end
      WAIT_SJ: begin
        s_addr    = j;
        state_nxt = WRITE_SI;
      end
      WRITE_SI: begin
        s_addr    = i;
        s_data    = sj;
        s_wren    = 1'b1;
        state_nxt = WRITE_SJ;
      end
      WRITE_SJ: begin
        s_addr    = j;
        s_data    = si;
        s_wren    = 1'b1;
        state_nxt = READ_F;
      end
      READ_F: begin
        s_addr    = si + sj;
        rom_addr  = k;
        state_nxt = WAIT_F;
      end
      WAIT_F: begin
        s_addr    = si + sj;
        rom_addr  = k;
        state_nxt = WRITE_DEC;
      end
      WRITE_DEC: begin
        dec_addr  = k;
        dec_data  = plain;
        dec_wren  = 1'b1;
        state_nxt = NEXT_K;
      end
      NEXT_K:  state_nxt = (k == K_LAST) ? DONE : INC_I;
      DONE: begin
        done = 1'b1;
        if (!start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_s_memory_decrypt.sv
module tb_s_memory_decrypt;

  typedef struct packed {
    logic [1:0] g;
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [2:0] start;
  logic [2:0] ld_go;
  logic [7:0] s_addr [3];
  logic [7:0] s_data [3];
  logic [7:0] s_q [3];
  logic [7:0] rom_addr [3];
  logic [7:0] rom_q [3];
  logic [7:0] dec_addr [3];
  logic [7:0] dec_data [3];
  logic [2:0] s_wren, dec_wren, done, text_ok;

  logic [7:0] s_mem [3][256];
  logic [7:0] rom_mem [3][256];
  logic [7:0] dec_mem [3][256];
  logic [7:0] s_init [256];
  logic [7:0] m_s [256];
  logic       m_ok;

  int  checks = 0;
  int  failures = 0;
  wr_t exp_q [$];
  wr_t s_log [$];
  int  s_wr_cnt [3];
  int  dec_wr_cnt [3];
  wr_t mon_w, mon_e;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    s_memory_decrypt #(.MSG_LEN(g == 0 ? 2 : (g == 1 ? 32 : 256))) u_dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start[g]),
      .s_addr   (s_addr[g]),
      .s_data   (s_data[g]),
      .s_wren   (s_wren[g]),
      .s_q      (s_q[g]),
      .rom_addr (rom_addr[g]),
      .rom_q    (rom_q[g]),
      .dec_addr (dec_addr[g]),
      .dec_data (dec_data[g]),
      .dec_wren (dec_wren[g]),
      .done     (done[g]),
      .text_ok  (text_ok[g])
    );
  end

  // synchronous memories; ld_go bulk-loads S from s_init
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (ld_go[g]) begin
        for (int a = 0; a < 256; a++) s_mem[g][a] <= s_init[a];
      end else if (s_wren[g]) begin
        s_mem[g][s_addr[g]] <= s_data[g];
      end
      s_q[g]   <= s_mem[g][s_addr[g]];
      rom_q[g] <= rom_mem[g][rom_addr[g]];
      if (dec_wren[g]) dec_mem[g][dec_addr[g]] <= dec_data[g];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every decrypted-RAM write pops the oldest expected write
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (s_wren[g]) begin
        s_wr_cnt[g]++;
        if (g == 0) begin
          mon_w = {2'(g), s_addr[g], s_data[g]};
          s_log.push_back(mon_w);
        end
      end
      if (dec_wren[g]) begin
        dec_wr_cnt[g]++;
        chk("dec_pending", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          mon_w = {2'(g), dec_addr[g], dec_data[g]};
          chk("dec_write", 64'(mon_w), 64'(mon_e));
        end
      end
    end
  end

  // reference RC4 PRGA over a copy of s_init
  task automatic run_model(input int g, input int len);
    logic [7:0] i, j, t, f, d;
    wr_t w;
    i = 8'd0;
    j = 8'd0;
    m_ok = 1'b1;
    for (int a = 0; a < 256; a++) m_s[a] = s_init[a];
    for (int k = 0; k < len; k++) begin
      i = i + 8'd1;
      j = j + m_s[i];
      t = m_s[i];
      m_s[i] = m_s[j];
      m_s[j] = t;
      f = m_s[8'(m_s[i] + m_s[j])];
      d = f ^ rom_mem[g][k];
      if (!(((d >= 8'h61) && (d <= 8'h7a)) || (d == 8'h20))) m_ok = 1'b0;
      w = {2'(g), 8'(k), d};
      exp_q.push_back(w);
    end
  endtask

  task automatic do_load(input int g);
    @(negedge clk);
    ld_go[g] = 1'b1;
    @(negedge clk);
    ld_go[g] = 1'b0;
  endtask

  task automatic start_and_wait(input int g, input int budget, output int edges);
    @(negedge clk);
    start[g] = 1'b1;
    @(posedge clk);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!done[g] && edges < budget);
    chk($sformatf("done_seen%0d", g), 64'(done[g]), 64'd1);
  endtask

  task automatic chk_s(input int g);
    for (int a = 0; a < 256; a++)
      chk($sformatf("s_final%0d_%0d", g, a), 64'(s_mem[g][a]), 64'(m_s[a]));
  endtask

  task automatic stop_run(input int g);
    @(negedge clk);
    start[g] = 1'b0;
    @(posedge clk);
    #1;
    chk($sformatf("done_clear%0d", g), 64'(done[g]), 64'd0);
  endtask

  task automatic set_identity();
    for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
  endtask

  int edges, n, cyc, r;
  logic [7:0] t8;

  initial begin
    reset_n = 1'b0;
    start   = 3'b000;
    ld_go   = 3'b000;
    for (int g = 0; g < 3; g++) begin
      s_wr_cnt[g] = 0;
      dec_wr_cnt[g] = 0;
      for (int a = 0; a < 256; a++) begin
        rom_mem[g][a] = 8'h00;
        s_mem[g][a]   = 8'h00;
        dec_mem[g][a] = 8'h00;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++)
      chk($sformatf("reset_outs%0d", g),
          64'({s_addr[g], s_data[g], rom_addr[g], dec_addr[g], dec_data[g],
               s_wren[g], dec_wren[g], done[g], text_ok[g]}), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // identity S, zero ROM, two bytes
    set_identity();
    do_load(0);
    s_log.delete();
    run_model(0, 2);
    start_and_wait(0, 100, edges);
    chk("t1_done_edges", 64'(edges), 64'd24);
    chk("t1_dec0", 64'(dec_mem[0][0]), 64'h02);
    chk("t1_dec1", 64'(dec_mem[0][1]), 64'h05);
    chk("t1_text_ok", 64'(text_ok[0]), 64'd0);
    chk("t1_sb_drained", 64'(exp_q.size()), 64'd0);
    chk("t1_s_writes", 64'(s_log.size()), 64'd4);
    if (s_log.size() >= 4) begin
      chk("ieqj_wr0", 64'(s_log[0]), 64'({2'd0, 8'd1, 8'd1}));
      chk("ieqj_wr1", 64'(s_log[1]), 64'({2'd0, 8'd1, 8'd1}));
      chk("swap_wr2", 64'(s_log[2]), 64'({2'd0, 8'd2, 8'd3}));
      chk("swap_wr3", 64'(s_log[3]), 64'({2'd0, 8'd3, 8'd2}));
    end
    stop_run(0);

    // plaintext bytes keep text_ok high
    rom_mem[0][0] = 8'h63;
    rom_mem[0][1] = 8'h25;
    do_load(0);
    run_model(0, 2);
    start_and_wait(0, 100, edges);
    chk("t2_done_edges", 64'(edges), 64'd24);
    chk("t2_dec0", 64'(dec_mem[0][0]), 64'h61);
    chk("t2_dec1", 64'(dec_mem[0][1]), 64'h20);
    chk("t2_text_ok", 64'(text_ok[0]), 64'd1);
    stop_run(0);

    // random permutation and random ROM, 32 bytes
    set_identity();
    for (int a = 255; a > 0; a--) begin
      r = int'($urandom_range(a, 0));
      t8 = s_init[a];
      s_init[a] = s_init[r];
      s_init[r] = t8;
    end
    for (int a = 0; a < 256; a++) rom_mem[1][a] = 8'($urandom);
    do_load(1);
    run_model(1, 32);
    s_wr_cnt[1] = 0;
    dec_wr_cnt[1] = 0;
    start_and_wait(1, 1000, edges);
    chk("t3_done_edges", 64'(edges), 64'd384);
    chk("t3_s_writes", 64'(s_wr_cnt[1]), 64'd64);
    chk("t3_dec_writes", 64'(dec_wr_cnt[1]), 64'd32);
    chk("t3_text_ok", 64'(text_ok[1]), 64'(m_ok));
    chk("t3_sb_drained", 64'(exp_q.size()), 64'd0);
    chk_s(1);
    stop_run(1);

    // reset during WRITE_SI of byte 5
    do_load(1);
    run_model(1, 32);
    s_wr_cnt[1] = 0;
    dec_wr_cnt[1] = 0;
    @(negedge clk);
    start[1] = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 11 && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (s_wren[1]) n++;
    end
    chk("t4_reach_write_si", 64'(n), 64'd11);
    reset_n = 1'b0;
    start[1] = 1'b0;
    @(posedge clk);
    #1;
    chk("t4_abort_outs",
        64'({s_addr[1], s_wren[1], dec_wren[1], done[1], text_ok[1]}), 64'd1);
    chk("t4_dec_before_abort", 64'(dec_wr_cnt[1]), 64'd5);
    chk("t4_sb_left", 64'(exp_q.size()), 64'd27);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    s_wr_cnt[1] = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("t4_idle_quiet", 64'({s_wr_cnt[1][7:0], done[1]}), 64'd0);
    do_load(1);
    run_model(1, 32);
    dec_wr_cnt[1] = 0;
    start_and_wait(1, 1000, edges);
    chk("t4_restart_edges", 64'(edges), 64'd384);
    chk("t4_restart_dec_writes", 64'(dec_wr_cnt[1]), 64'd32);
    chk("t4_restart_text_ok", 64'(text_ok[1]), 64'(m_ok));
    chk_s(1);
    stop_run(1);

    // full 256-byte message, i wraps on the last byte
    set_identity();
    for (int a = 0; a < 256; a++) rom_mem[2][a] = 8'($urandom);
    do_load(2);
    run_model(2, 256);
    dec_wr_cnt[2] = 0;
    start_and_wait(2, 4000, edges);
    chk("t5_done_edges", 64'(edges), 64'd3072);
    chk("t5_dec_writes", 64'(dec_wr_cnt[2]), 64'd256);
    chk("t5_sb_drained", 64'(exp_q.size()), 64'd0);
    chk("t5_text_ok", 64'(text_ok[2]), 64'(m_ok));
    chk_s(2);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("t5_done_hold", 64'(done[2]), 64'd1);
    end
    stop_run(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
